// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_evt_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BITS = 1'b1
    } ps2_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; a push into a full FIFO is accepted only
// when a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   cnt_t;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    ptr_t wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    cnt_t cnt_q, cnt_d;
    logic do_push, do_pop;

    assign full    = (cnt_q == cnt_t'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + ptr_t'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + ptr_t'(1);
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + cnt_t'(1);
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - cnt_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: pin synchronisation, clock deglitch, frame decode,
// E0/F0 prefix folding and a queue of decoded key events.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned FILTER_LEN  = 4,
    parameter int unsigned TIMEOUT_CYC = 5000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ps2_clk,
    input  logic                          ps2_dat,
    input  logic                          read_next,
    input  logic                          clr_ovf,
    output logic                          ready,
    output logic [7:0]                    data,
    output logic                          is_ext,
    output logic                          is_break,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          timeout_err
);

    localparam int unsigned FCW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TCW = $clog2(TIMEOUT_CYC + 1);

    logic ck_s1_q, ck_s1_d, ck_s2_q, ck_s2_d;
    logic dt_s1_q, dt_s1_d, dt_s2_q, dt_s2_d;
    logic filt_q, filt_d;
    logic [FCW-1:0] fcnt_q, fcnt_d;
    ps2_state_e state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic [8:0] sr_q, sr_d;
    logic [TCW-1:0] tcnt_q, tcnt_d;
    logic ext_q, ext_d, brk_q, brk_d;
    logic ovf_q, ovf_d;
    logic perr_q, perr_d, ferr_q, ferr_d, terr_q, terr_d;
    logic strobe, push;
    logic fifo_full, fifo_empty;
    ps2_evt_t push_evt, head;

    always_comb begin
        ck_s1_d = ps2_clk;
        ck_s2_d = ck_s1_q;
        dt_s1_d = ps2_dat;
        dt_s2_d = dt_s1_q;
        filt_d  = filt_q;
        fcnt_d  = '0;
        // Run length of samples disagreeing with the filtered level; any agreeing sample restarts it.
        if (ck_s2_q != filt_q) begin
            if (fcnt_q == FCW'(FILTER_LEN - 1)) begin
                filt_d = ~filt_q;
            end else begin
                fcnt_d = fcnt_q + FCW'(1);
            end
        end
        strobe = filt_q && !filt_d;
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        sr_d          = sr_q;
        tcnt_d        = '0;
        ext_d         = ext_q;
        brk_d         = brk_q;
        perr_d        = 1'b0;
        ferr_d        = 1'b0;
        terr_d        = 1'b0;
        push          = 1'b0;
        push_evt.ext  = ext_q;
        push_evt.brk  = brk_q;
        push_evt.code = sr_q[7:0];
        case (state_q)
            ST_IDLE: begin
                if (strobe) begin
                    if (!dt_s2_q) begin
                        state_d = ST_BITS;
                        idx_d   = 4'd1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            ST_BITS: begin
                if (strobe) begin
                    if (idx_q == 4'd10) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                        // sr_q holds data bits 1..8 in [7:0] and the parity bit in [8].
                        if (!dt_s2_q) begin
                            ferr_d = 1'b1;
                        end else if (!(^sr_q)) begin
                            perr_d = 1'b1;
                        end else if (sr_q[7:0] == PS2_EXT) begin
                            ext_d = 1'b1;
                        end else if (sr_q[7:0] == PS2_BRK) begin
                            brk_d = 1'b1;
                        end else begin
                            push  = 1'b1;
                            ext_d = 1'b0;
                            brk_d = 1'b0;
                        end
                    end else begin
                        sr_d  = {dt_s2_q, sr_q[8:1]};
                        idx_d = idx_q + 4'd1;
                    end
                end else if (tcnt_q == TCW'(TIMEOUT_CYC - 1)) begin
                    terr_d  = 1'b1;
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else begin
                    tcnt_d = tcnt_q + TCW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // A full FIFO only drops the event when no pop frees a slot in the same cycle.
    always_comb begin
        ovf_d = ovf_q;
        if (push && fifo_full && !read_next) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ck_s1_q <= 1'b1;
            ck_s2_q <= 1'b1;
            dt_s1_q <= 1'b1;
            dt_s2_q <= 1'b1;
            filt_q  <= 1'b1;
            fcnt_q  <= '0;
            state_q <= ST_IDLE;
            idx_q   <= '0;
            sr_q    <= '0;
            tcnt_q  <= '0;
            ext_q   <= 1'b0;
            brk_q   <= 1'b0;
            ovf_q   <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            ck_s1_q <= ck_s1_d;
            ck_s2_q <= ck_s2_d;
            dt_s1_q <= dt_s1_d;
            dt_s2_q <= dt_s2_d;
            filt_q  <= filt_d;
            fcnt_q  <= fcnt_d;
            state_q <= state_d;
            idx_q   <= idx_d;
            sr_q    <= sr_d;
            tcnt_q  <= tcnt_d;
            ext_q   <= ext_d;
            brk_q   <= brk_d;
            ovf_q   <= ovf_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            terr_q  <= terr_d;
        end
    end

    sync_fifo #(
        .WIDTH($bits(ps2_evt_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (push_evt),
        .pop     (read_next),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (count)
    );

    assign ready       = !fifo_empty;
    assign data        = head.code;
    assign is_ext      = head.ext;
    assign is_break    = head.brk;
    assign overflow    = ovf_q;
    assign parity_err  = perr_q;
    assign frame_err   = ferr_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: directed and random PS/2 frames against a queue model.
module tb_ps2_rx_fifo;

    localparam int DEPTH = 4;
    localparam int FLEN  = 4;
    localparam int TOUT  = 300;

    logic       clk = 1'b0;
    logic       rst, ps2_clk, ps2_dat, read_next, clr_ovf;
    logic       ready, is_ext, is_break, overflow;
    logic [7:0] data;
    logic [2:0] count;
    logic       parity_err, frame_err, timeout_err;

    always #5 clk = ~clk;

    ps2_rx_fifo #(
        .FIFO_DEPTH (DEPTH),
        .FILTER_LEN (FLEN),
        .TIMEOUT_CYC(TOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_dat    (ps2_dat),
        .read_next  (read_next),
        .clr_ovf    (clr_ovf),
        .ready      (ready),
        .data       (data),
        .is_ext     (is_ext),
        .is_break   (is_break),
        .count      (count),
        .overflow   (overflow),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .timeout_err(timeout_err)
    );

    int checks   = 0;
    int failures = 0;
    int perr_seen = 0, ferr_seen = 0, terr_seen = 0;
    int exp_perr  = 0, exp_ferr  = 0, exp_terr  = 0;

    logic [9:0] q[$];
    bit m_ext = 0, m_brk = 0, m_ovf = 0;

    // Counts high cycles, so a pulse wider than one cycle shows up as an extra event.
    always @(negedge clk) begin
        if (!rst) begin
            if (parity_err)  perr_seen++;
            if (frame_err)   ferr_seen++;
            if (timeout_err) terr_seen++;
        end
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " count"}, 32'(count), q.size());
        chk({tag, " ready"}, 32'(ready), 32'(q.size() != 0));
        chk({tag, " overflow"}, 32'(overflow), 32'(m_ovf));
        if (q.size() != 0)
            chk({tag, " head"}, 32'({is_ext, is_break, data}), 32'(q[0]));
        chk({tag, " parity_err"}, perr_seen, exp_perr);
        chk({tag, " frame_err"}, ferr_seen, exp_ferr);
        chk({tag, " timeout_err"}, terr_seen, exp_terr);
    endtask

    function automatic logic [10:0] mk(input logic [7:0] b, input bit pbad, input bit sbad);
        logic par;
        par = (~^b) ^ pbad;
        return {~sbad, par, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int nbits,
                             input bit pop_stop, input int glitch_at);
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = bits[i];
            if (i == glitch_at) begin
                wait_n(2);
                ps2_clk = 1'b0;
                wait_n(FLEN - 1);
                ps2_clk = 1'b1;
                wait_n(6);
            end
            wait_n(4);
            ps2_clk = 1'b0;
            if (pop_stop && i == 10) begin
                // Stop-bit strobe lands on the (FLEN+2)-th edge after the pin falls.
                wait_n(FLEN + 1);
                read_next = 1'b1;
                wait_n(1);
                read_next = 1'b0;
                wait_n(8 - FLEN - 2);
            end else begin
                wait_n(8);
            end
            ps2_clk = 1'b1;
            wait_n(4);
        end
        ps2_dat = 1'b1;
        wait_n(8);
    endtask

    // kind: 0 good, 1 parity flipped, 2 stop bit low
    task automatic frame(input logic [7:0] b, input int kind, input bit pop_stop, input int glitch_at);
        send_bits(mk(b, kind == 1, kind == 2), 11, pop_stop, glitch_at);
        if (pop_stop && q.size() > 0) void'(q.pop_front());
        if (kind == 1) exp_perr++;
        else if (kind == 2) exp_ferr++;
        else if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else begin
            if (q.size() < DEPTH) q.push_back({m_ext, m_brk, b});
            else m_ovf = 1;
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    task automatic pop1(input string tag);
        read_next = 1'b1;
        wait_n(1);
        read_next = 1'b0;
        if (q.size() > 0) void'(q.pop_front());
        check_all(tag);
    endtask

    task automatic clear_ovf();
        clr_ovf = 1'b1;
        wait_n(1);
        clr_ovf = 1'b0;
        m_ovf = 0;
        check_all("clr_ovf");
    endtask

    task automatic drain(input string tag);
        while (q.size() > 0) pop1(tag);
    endtask

    initial begin
        rst = 1'b1; ps2_clk = 1'b1; ps2_dat = 1'b1; read_next = 1'b0; clr_ovf = 1'b0;
        wait_n(4);
        rst = 1'b0;
        wait_n(1);
        check_all("reset");

        frame(8'h1C, 0, 0, -1);  check_all("byte_1c");
        drain("drain_1c");
        frame(8'hE0, 0, 0, -1);
        frame(8'hF0, 0, 0, -1);
        frame(8'h74, 0, 0, -1);  check_all("ext_brk_74");
        frame(8'h74, 0, 0, -1);  check_all("plain_74");
        drain("drain_74");

        frame(8'h1C, 1, 0, -1);  check_all("parity_bad");
        frame(8'h1C, 2, 0, -1);  check_all("stop_bad");
        send_bits(11'h001, 1, 0, -1);
        exp_ferr++;
        check_all("start_bad");

        for (int i = 0; i < 5; i++) frame(8'h11 + 8'(i), 0, 0, -1);
        check_all("overflow_fill");
        drain("overflow_drain");
        pop1("pop_empty");
        clear_ovf();

        for (int i = 0; i < 4; i++) frame(8'h21 + 8'(i), 0, 0, -1);
        frame(8'h25, 0, 1, -1);  check_all("full_push_pop");
        drain("full_push_pop_drain");

        send_bits(mk(8'h5A, 0, 0), 4, 0, -1);
        wait_n(TOUT + 20);
        exp_terr++;
        check_all("timeout");
        frame(8'h2A, 0, 0, -1);  check_all("after_timeout");
        frame(8'h35, 0, 0, 5);   check_all("glitch");
        drain("glitch_drain");

        frame(8'h6B, 0, 0, -1);
        send_bits(mk(8'h55, 0, 0), 5, 0, -1);
        rst = 1'b1;
        wait_n(2);
        rst = 1'b0;
        q.delete(); m_ext = 0; m_brk = 0; m_ovf = 0;
        wait_n(1);
        check_all("mid_frame_reset");
        frame(8'h3C, 0, 0, -1);  check_all("after_reset");

        for (int it = 0; it < 25; it++) begin
            int r, k, npop;
            logic [7:0] b;
            bit ps;
            r    = $urandom_range(0, 7);
            b    = (r == 0) ? 8'hE0 : (r == 1) ? 8'hF0 : 8'($urandom);
            k    = $urandom_range(0, 5);
            ps   = ($urandom_range(0, 3) == 0);
            frame(b, (k == 0) ? 1 : (k == 1) ? 2 : 0, ps, -1);
            check_all("rand_frame");
            npop = $urandom_range(0, 2);
            for (int p = 0; p < npop; p++) pop1("rand_pop");
            if ($urandom_range(0, 4) == 0) clear_ovf();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
